mux_n_pipe: RTL and testbench
=============================

# mux_n_pipe

Parametrised N-way registered selector with a valid/ready handshake for the RV32I datapath, generalising the combinational 2:1 `Mux2x1` to N channels. On each accepted transfer it captures the selected channel's data and a channel tag into a two-entry output skid buffer. This sustains one transfer per cycle under backpressure. Upstream sees a registered `in_ready` with no combinational path from `sal_ready`. Out-of-range selects are flagged rather than silently aliased.

## Interface
- `WIDTH`, 32, data width per channel
- `N`, 4, number of input channels (N ≥ 2)
- `SELW`, `$clog2(N)` (1 when N = 2), select width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `e`  in  N*WIDTH  channel inputs; channel i at bits [i*WIDTH +: WIDTH]
- `sel`  in  SELW  channel select, sampled only on input fire
- `in_valid`  in  1  upstream offers `e`/`sel`
- `in_ready`  out  1  block can accept; driven from a register
- `sal`  out  WIDTH  selected data, head entry
- `sal_sel`  out  SELW  select value that produced `sal`
- `sal_err`  out  1  head entry had `sel` ≥ N
- `sal_valid`  out  1  head entry valid
- `sal_ready`  in  1  downstream accepts head

## Operation
- Input fire: `in_valid & in_ready`. Output fire: `sal_valid & sal_ready`.
- Captured entry: {data, sel, err}.
  - If `sel` < N: data = `e[sel*WIDTH +: WIDTH]`, err = 0.
  - If `sel` ≥ N (possible only when N is not a power of 2): data = 0, err = 1.
- Storage: main register drives `sal`/`sal_sel`/`sal_err`; one skid register.
- States, by occupancy:
  - EMPTY: `sal_valid` = 0, `in_ready` = 1.
    - in fire → ONE; main ← new entry.
  - ONE: `sal_valid` = 1, `in_ready` = 1.
    - in fire & out fire → ONE; main ← new entry.
    - in fire only → TWO; skid ← new entry.
    - out fire only → EMPTY; main contents are don't-care but hold their value.
    - neither → hold.
  - TWO: `sal_valid` = 1, `in_ready` = 0.
    - out fire → ONE; main ← skid.
    - otherwise hold.
- Order is strictly FIFO; no entry is dropped or duplicated.
- `sal`, `sal_sel` and `sal_err` are stable while `sal_valid & !sal_ready`.
- `in_valid` while `in_ready` = 0 has no effect; `e`/`sel` are ignored.
- Changes on `e` or `sel` outside an input fire never affect outputs.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state = EMPTY, `sal_valid` = 0, `in_ready` = 1;
  - `sal` = 0, `sal_sel` = 0, `sal_err` = 0; skid cleared to 0.
- While `rst` is high, no fire takes effect.
- Reset asserted mid-operation discards all entries. The first edge after deassertion behaves as EMPTY.
- Latency: an input fire at edge k makes the entry visible on `sal` and raises `sal_valid` right after edge k (one cycle).
- Throughput: 1 transfer/cycle whenever `sal_ready` = 1 continuously.
- `in_ready` falls after the edge entering TWO. It rises after the edge leaving TWO.
- No combinational path from `sal_ready` or `in_valid` to `in_ready`.

## Test plan
- Reset, then WIDTH = 32, N = 4, e = {0xDDDD0000, 0xCCCC0000, 0xBBBB0000, 0x0000ABCD}, sel = 0, one fire → next cycle `sal` = 0x0000ABCD, `sal_sel` = 0, `sal_valid` = 1, `sal_err` = 0.
- Streaming with `sal_ready` = 1 and sel sequence 0,1,2,3 on consecutive cycles → `sal` = 0x0000ABCD, 0xBBBB0000, 0xCCCC0000, 0xDDDD0000 on consecutive cycles; `in_ready` stays 1.
- `sal_ready` = 0 with three offers (sel = 1, 2, 3):
  - two accepted, then `in_ready` = 0 and the third is held off;
  - `sal` stays 0xBBBB0000;
  - raising `sal_ready` drains 0xBBBB0000, then 0xCCCC0000, then accepts and delivers 0xDDDD0000.
- N = 3, sel = 3 → `sal` = 0, `sal_err` = 1, `sal_sel` = 3. A following sel = 2 gives `sal_err` = 0.
- `rst` asserted mid-cycle while in TWO → `sal_valid` drops to 0 and `in_ready` goes to 1 immediately, without waiting for a clock edge. After release, sel = 1 delivers 0xBBBB0000 with no stale data.
- `e`/`sel` toggled while `in_valid` = 0 and while stalled in TWO → `sal` unchanged.

Source files
------------

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - N-way registered selector with valid/ready handshake and two-entry skid buffer
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   e         - N channel inputs, channel i at [i*WIDTH +: WIDTH]
//   sel       - channel select, sampled only on input fire
//   in_valid  - upstream offers e/sel
//   in_ready  - block can accept (registered)
//   sal       - head entry data
//   sal_sel   - select value that produced sal
//   sal_err   - head entry had an out-of-range select
//   sal_valid - head entry valid
//   sal_ready - downstream accepts head
module mux_n_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   e,
    input  logic [SELW-1:0]      sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     sal,
    output logic [SELW-1:0]      sal_sel,
    output logic                 sal_err,
    output logic                 sal_valid,
    input  logic                 sal_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] skid_data;
    logic [SELW-1:0]  skid_sel;
    logic             skid_err;

    logic [WIDTH-1:0] new_data;
    logic             new_err;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = sal_valid & sal_ready;

    // An unmatched select (only reachable when N is not a power of two)
    // yields zero data and raises the error flag instead of aliasing.
    always_comb begin
        new_data = '0;
        new_err  = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                new_data = e[i*WIDTH +: WIDTH];
                new_err  = 1'b0;
            end
        end
    end

    // in_ready and sal_valid are kept as registers that track the
    // occupancy state, so neither has a combinational input path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            sal_valid <= 1'b0;
            sal       <= '0;
            sal_sel   <= '0;
            sal_err   <= 1'b0;
            skid_data <= '0;
            skid_sel  <= '0;
            skid_err  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        sal       <= new_data;
                        sal_sel   <= sel;
                        sal_err   <= new_err;
                        sal_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        sal     <= new_data;
                        sal_sel <= sel;
                        sal_err <= new_err;
                    end else if (in_fire) begin
                        skid_data <= new_data;
                        skid_sel  <= sel;
                        skid_err  <= new_err;
                        in_ready  <= 1'b0;
                        state     <= TWO;
                    end else if (out_fire) begin
                        // Main register keeps its stale contents; only valid drops.
                        sal_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        sal      <= skid_data;
                        sal_sel  <= skid_sel;
                        sal_err  <= skid_err;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    sal_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb/tb_mux_n_pipe.sv - self-checking bench for mux_n_pipe (N=4 and N=3 instances)
module tb_mux_n_pipe;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [127:0] e;
    logic [1:0]   sel;
    logic         in_valid;
    logic         sal_ready;

    logic         in_ready4, sal_valid4, sal_err4;
    logic [W-1:0] sal4;
    logic [1:0]   sal_sel4;
    logic         in_ready3, sal_valid3, sal_err3;
    logic [W-1:0] sal3;
    logic [1:0]   sal_sel3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d4;
        logic        r4;
        logic [31:0] d3;
        logic        r3;
        logic [1:0]  s;
    } ent_t;

    ent_t q[$];

    localparam logic [127:0] EV = {32'hDDDD0000, 32'hCCCC0000, 32'hBBBB0000, 32'h0000ABCD};

    mux_n_pipe #(.WIDTH(W), .N(4)) u4 (
        .clk(clk), .rst(rst), .e(e), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready4), .sal(sal4), .sal_sel(sal_sel4), .sal_err(sal_err4),
        .sal_valid(sal_valid4), .sal_ready(sal_ready)
    );

    mux_n_pipe #(.WIDTH(W), .N(3)) u3 (
        .clk(clk), .rst(rst), .e(e[95:0]), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready3), .sal(sal3), .sal_sel(sal_sel3), .sal_err(sal_err3),
        .sal_valid(sal_valid3), .sal_ready(sal_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t make_ent(input logic [127:0] ev, input logic [1:0] s);
        ent_t x;
        int   k;
        k    = int'(s);
        x.s  = s;
        x.d4 = 32'((ev >> (k * W)) & 128'hFFFFFFFF);
        x.r4 = 1'b0;
        if (k < 3) begin
            x.d3 = x.d4;
            x.r3 = 1'b0;
        end else begin
            x.d3 = 32'h0;
            x.r3 = 1'b1;
        end
        return x;
    endfunction

    task automatic check_model(input string tag);
        logic ev_v, ev_r;
        ev_v = (q.size() > 0);
        ev_r = (q.size() < 2);
        chk({tag, ".valid4"}, 64'(sal_valid4), 64'(ev_v));
        chk({tag, ".ready4"}, 64'(in_ready4), 64'(ev_r));
        chk({tag, ".valid3"}, 64'(sal_valid3), 64'(ev_v));
        chk({tag, ".ready3"}, 64'(in_ready3), 64'(ev_r));
        if (ev_v) begin
            chk({tag, ".sal4"}, 64'(sal4), 64'(q[0].d4));
            chk({tag, ".sel4"}, 64'(sal_sel4), 64'(q[0].s));
            chk({tag, ".err4"}, 64'(sal_err4), 64'(q[0].r4));
            chk({tag, ".sal3"}, 64'(sal3), 64'(q[0].d3));
            chk({tag, ".sel3"}, 64'(sal_sel3), 64'(q[0].s));
            chk({tag, ".err3"}, 64'(sal_err3), 64'(q[0].r3));
        end
    endtask

    // Drive one cycle of inputs after a falling edge, advance the model
    // across the rising edge, and check at the next falling edge.
    task automatic cyc(input string tag, input logic iv, input logic sr,
                       input logic [1:0] s, input logic [127:0] ev);
        logic inf, outf;
        in_valid  = iv;
        sal_ready = sr;
        sel       = s;
        e         = ev;
        inf  = iv && (q.size() < 2) && !rst;
        outf = sr && (q.size() > 0) && !rst;
        @(posedge clk);
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(make_ent(ev, s));
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        rst = 1'b1; e = '0; sel = '0; in_valid = 1'b0; sal_ready = 1'b0;
        #1;
        chk("rst.valid", 64'(sal_valid4), 64'd0);
        chk("rst.ready", 64'(in_ready4), 64'd1);
        chk("rst.sal",   64'(sal4), 64'd0);
        chk("rst.sel",   64'(sal_sel4), 64'd0);
        chk("rst.err",   64'(sal_err4), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        cyc("first", 1'b1, 1'b0, 2'd0, EV);
        chk("first.sal", 64'(sal4), 64'h0000ABCD);

        cyc("strm0", 1'b1, 1'b1, 2'd0, EV);
        chk("strm0.sal", 64'(sal4), 64'h0000ABCD);
        cyc("strm1", 1'b1, 1'b1, 2'd1, EV);
        chk("strm1.sal", 64'(sal4), 64'hBBBB0000);
        cyc("strm2", 1'b1, 1'b1, 2'd2, EV);
        chk("strm2.sal", 64'(sal4), 64'hCCCC0000);
        cyc("strm3", 1'b1, 1'b1, 2'd3, EV);
        chk("strm3.sal", 64'(sal4), 64'hDDDD0000);
        cyc("drain", 1'b0, 1'b1, 2'd0, EV);

        cyc("bp1", 1'b1, 1'b0, 2'd1, EV);
        cyc("bp2", 1'b1, 1'b0, 2'd2, EV);
        chk("bp2.ready", 64'(in_ready4), 64'd0);
        cyc("bp3", 1'b1, 1'b0, 2'd3, EV);
        chk("bp3.sal", 64'(sal4), 64'hBBBB0000);
        // Stalled in TWO: toggling e/sel must not disturb the outputs.
        cyc("tgl_two", 1'b1, 1'b0, 2'd0, ~EV);
        chk("tgl_two.sal", 64'(sal4), 64'hBBBB0000);
        cyc("rel1", 1'b1, 1'b1, 2'd3, EV);
        chk("rel1.sal", 64'(sal4), 64'hCCCC0000);
        cyc("rel2", 1'b1, 1'b1, 2'd3, EV);
        chk("rel2.sal", 64'(sal4), 64'hDDDD0000);
        cyc("rel3", 1'b0, 1'b1, 2'd0, EV);

        cyc("n3err", 1'b1, 1'b1, 2'd3, EV);
        chk("n3err.err3", 64'(sal_err3), 64'd1);
        chk("n3err.sal3", 64'(sal3), 64'd0);
        chk("n3err.sel3", 64'(sal_sel3), 64'd3);
        cyc("n3ok", 1'b1, 1'b1, 2'd2, EV);
        chk("n3ok.err3", 64'(sal_err3), 64'd0);

        // in_valid low with toggled e/sel: head holds.
        cyc("idle_tgl", 1'b0, 1'b0, 2'd1, ~EV);
        chk("idle_tgl.sal", 64'(sal4), 64'hCCCC0000);

        // Fill to TWO, then assert reset between clock edges.
        cyc("fill", 1'b1, 1'b0, 2'd0, EV);
        #2 rst = 1'b1;
        #1;
        chk("arst.valid", 64'(sal_valid4), 64'd0);
        chk("arst.ready", 64'(in_ready4), 64'd1);
        chk("arst.valid3", 64'(sal_valid3), 64'd0);
        q.delete();
        @(negedge clk);
        cyc("in_rst", 1'b1, 1'b1, 2'd2, EV);
        rst = 1'b0;
        cyc("post_rst", 1'b1, 1'b0, 2'd1, EV);
        chk("post_rst.sal", 64'(sal4), 64'hBBBB0000);
        cyc("post_drain", 1'b0, 1'b1, 2'd0, EV);

        for (int i = 0; i < 400; i++) begin
            cyc("rnd", 1'($urandom), 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                {$urandom, $urandom, $urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
